// File: rtl/rld_multi_port_arb.sv
// rld_multi_port_arb
//   N-port user-side front end for the RLDRAM-II controller. It arbitrates N
//   independent command streams onto the controller's single command
//   interface using round-robin with direction-preserving grant bursts. It
//   returns read data to the issuing port in order, using a FIFO of port
//   tags.
//
// Ports
//   sysClk, sysReset       controller clock, synchronous active-high reset
//   port_cmd_valid/ready   per-port command handshake (ready one-hot or zero)
//   port_cmd_wr            per-port direction (1 = write)
//   port_addr, port_wdata  flattened per-port address / write data
//   port_rd_valid          one-hot read-return strobe
//   port_rd_data           read data, broadcast to all ports
//   ctl_cmd_*              registered command slot towards the controller
//   ctl_rd_valid/data      read data from the controller
//   rd_outstanding         reads issued and not yet returned
//   err_unexp_rd           sticky: read data arrived with no read outstanding
module rld_multi_port_arb #(
  parameter int NUM_PORTS    = 4,
  parameter int APP_AD_WIDTH = 26,
  parameter int APP_DW       = 144,
  parameter int RD_TAG_DEPTH = 16,
  parameter int HOLD_MAX     = 4
) (
  input  logic                              sysClk,
  input  logic                              sysReset,
  input  logic [NUM_PORTS-1:0]              port_cmd_valid,
  output logic [NUM_PORTS-1:0]              port_cmd_ready,
  input  logic [NUM_PORTS-1:0]              port_cmd_wr,
  input  logic [NUM_PORTS*APP_AD_WIDTH-1:0] port_addr,
  input  logic [NUM_PORTS*APP_DW-1:0]       port_wdata,
  output logic [NUM_PORTS-1:0]              port_rd_valid,
  output logic [APP_DW-1:0]                 port_rd_data,
  output logic                              ctl_cmd_valid,
  input  logic                              ctl_cmd_ready,
  output logic                              ctl_cmd_wr,
  output logic [APP_AD_WIDTH-1:0]           ctl_addr,
  output logic [APP_DW-1:0]                 ctl_wdata,
  input  logic                              ctl_rd_valid,
  input  logic [APP_DW-1:0]                 ctl_rd_data,
  output logic [$clog2(RD_TAG_DEPTH):0]     rd_outstanding,
  output logic                              err_unexp_rd
);

  localparam int PW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int TAW = $clog2(RD_TAG_DEPTH);
  localparam int CW  = TAW + 1;
  localparam int HW  = $clog2(HOLD_MAX + 1);

  localparam logic [0:0] ST_ARB  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  function automatic logic [PW-1:0] next_port(input logic [PW-1:0] p);
    return (p == PW'(NUM_PORTS - 1)) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [NUM_PORTS-1:0] onehot(input logic [PW-1:0] p);
    logic [NUM_PORTS-1:0] r;
    r    = '0;
    r[p] = 1'b1;
    return r;
  endfunction

  // arbiter state
  logic [0:0]           state;
  logic [PW-1:0]        rr_ptr;
  logic [PW-1:0]        owner;
  logic                 owner_dir;
  logic [HW-1:0]        hold_cnt;

  // read tag FIFO
  logic [PW-1:0]        tag_mem [RD_TAG_DEPTH];
  logic [TAW-1:0]       tag_wp;
  logic [TAW-1:0]       tag_rp;
  logic [CW-1:0]        tag_cnt;

  // command output slot and read-return registers
  logic                 cmd_vld_p1;
  logic                 cmd_wr_p1;
  logic [APP_AD_WIDTH-1:0] cmd_addr_p1;
  logic [APP_DW-1:0]    cmd_wdata_p1;
  logic [NUM_PORTS-1:0] rd_vld_p1;
  logic [APP_DW-1:0]    rd_data_p1;
  logic                 err_p1;

  logic [NUM_PORTS-1:0] elig;
  logic                 tag_full;
  logic                 slot_free;
  logic                 hold_ok;
  logic                 gnt_vld;
  logic [PW-1:0]        gnt_idx;
  logic [PW-1:0]        scan_base;
  logic                 fire;
  logic                 push;
  logic                 pop;
  logic [APP_AD_WIDTH-1:0] gnt_addr;
  logic [APP_DW-1:0]    gnt_wdata;

  // ---- stage p0: eligibility, grant selection, port handshake ----
  always_comb begin
    tag_full  = (tag_cnt == CW'(RD_TAG_DEPTH));
    slot_free = !cmd_vld_p1 || ctl_cmd_ready;
    // A pop in this cycle is not counted: full is judged on the registered count.
    for (int i = 0; i < NUM_PORTS; i++) begin
      elig[i] = port_cmd_valid[i] && (port_cmd_wr[i] || !tag_full);
    end
  end

  always_comb begin
    logic [PW-1:0] c_idx;
    int            c;
    c       = 0;
    c_idx   = '0;
    hold_ok = (state == ST_HOLD) && elig[owner] &&
              (port_cmd_wr[owner] == owner_dir) && (hold_cnt < HW'(HOLD_MAX));
    // Leaving a burst restarts the scan just past the owner in the same cycle.
    scan_base = (state == ST_HOLD) ? next_port(owner) : rr_ptr;
    gnt_vld   = 1'b0;
    gnt_idx   = '0;
    if (hold_ok) begin
      gnt_vld = 1'b1;
      gnt_idx = owner;
    end else begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        c = int'(scan_base) + k;
        if (c >= NUM_PORTS) c = c - NUM_PORTS;
        c_idx = PW'(c);
        if (!gnt_vld && elig[c_idx]) begin
          gnt_vld = 1'b1;
          gnt_idx = c_idx;
        end
      end
    end
  end

  always_comb begin
    gnt_addr  = '0;
    gnt_wdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (gnt_idx == PW'(i)) begin
        gnt_addr  = port_addr[i*APP_AD_WIDTH +: APP_AD_WIDTH];
        gnt_wdata = port_wdata[i*APP_DW +: APP_DW];
      end
    end
  end

  assign fire           = slot_free && gnt_vld && !sysReset;
  assign port_cmd_ready = fire ? onehot(gnt_idx) : '0;
  assign push           = fire && !port_cmd_wr[gnt_idx];
  assign pop            = ctl_rd_valid && (tag_cnt != '0) && !sysReset;

  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      state     <= ST_ARB;
      rr_ptr    <= '0;
      owner     <= '0;
      owner_dir <= 1'b0;
      hold_cnt  <= '0;
    end else if (slot_free) begin
      if (hold_ok) begin
        hold_cnt <= hold_cnt + HW'(1);
      end else if (gnt_vld) begin
        owner     <= gnt_idx;
        owner_dir <= port_cmd_wr[gnt_idx];
        hold_cnt  <= HW'(1);
        if (HOLD_MAX > 1) begin
          state  <= ST_HOLD;
          rr_ptr <= (state == ST_HOLD) ? next_port(owner) : rr_ptr;
        end else begin
          state  <= ST_ARB;
          rr_ptr <= next_port(gnt_idx);
        end
      end else if (state == ST_HOLD) begin
        state  <= ST_ARB;
        rr_ptr <= next_port(owner);
      end
    end
  end

  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      tag_wp  <= '0;
      tag_rp  <= '0;
      tag_cnt <= '0;
    end else begin
      if (push) tag_wp <= tag_wp + TAW'(1);
      if (pop)  tag_rp <= tag_rp + TAW'(1);
      case ({push, pop})
        2'b10:   tag_cnt <= tag_cnt + CW'(1);
        2'b01:   tag_cnt <= tag_cnt - CW'(1);
        default: tag_cnt <= tag_cnt;
      endcase
    end
  end

  always_ff @(posedge sysClk) begin
    if (push) tag_mem[tag_wp] <= gnt_idx;
  end

  // ---- stage p1: registered command slot and read return ----
  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      cmd_vld_p1   <= 1'b0;
      cmd_wr_p1    <= 1'b0;
      cmd_addr_p1  <= '0;
      cmd_wdata_p1 <= '0;
    end else if (slot_free) begin
      cmd_vld_p1 <= fire;
      if (fire) begin
        cmd_wr_p1    <= port_cmd_wr[gnt_idx];
        cmd_addr_p1  <= gnt_addr;
        cmd_wdata_p1 <= gnt_wdata;
      end
    end
  end

  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      rd_vld_p1  <= '0;
      rd_data_p1 <= '0;
      err_p1     <= 1'b0;
    end else begin
      rd_vld_p1 <= pop ? onehot(tag_mem[tag_rp]) : '0;
      if (pop) rd_data_p1 <= ctl_rd_data;
      if (ctl_rd_valid && (tag_cnt == '0)) err_p1 <= 1'b1;
    end
  end

  assign ctl_cmd_valid  = cmd_vld_p1;
  assign ctl_cmd_wr     = cmd_wr_p1;
  assign ctl_addr       = cmd_addr_p1;
  assign ctl_wdata      = cmd_wdata_p1;
  assign port_rd_valid  = rd_vld_p1;
  assign port_rd_data   = rd_data_p1;
  assign rd_outstanding = tag_cnt;
  assign err_unexp_rd   = err_p1;

endmodule

// File: doc/rld_multi_port_arb.md
Name: rld_multi_port_arb

Overview:
Parametrised N-port user-side front end for the RLDRAM-II memory controller. Arbitrates N independent command streams onto the controller's single command interface and steers returned read data back to the issuing port in order. Sits between user logic and the controller, in the controller's sysClk domain. Adds configurable channel count, grant-hold bursting and in-order read-return tagging.

Parameters:
NUM_PORTS, 4, number of user ports (2..8)
APP_AD_WIDTH, 26, command address width
APP_DW, 144, write/read data width per command
RD_TAG_DEPTH, 16, max outstanding reads (power of 2)
HOLD_MAX, 4, max consecutive grants to one port in the same direction (1 = pure round-robin)

Ports:
sysClk  in  1  controller clock; all logic on rising edge
sysReset  in  1  synchronous, active-high reset
port_cmd_valid  in  NUM_PORTS  per-port command request
port_cmd_ready  out  NUM_PORTS  per-port accept (one-hot or zero)
port_cmd_wr  in  NUM_PORTS  1 = write, 0 = read
port_addr  in  NUM_PORTS*APP_AD_WIDTH  flattened; port i at [i*APP_AD_WIDTH +: APP_AD_WIDTH]
port_wdata  in  NUM_PORTS*APP_DW  flattened write data
port_rd_valid  out  NUM_PORTS  one-hot read-return strobe
port_rd_data  out  APP_DW  read data, broadcast to all ports
ctl_cmd_valid  out  1  command to controller
ctl_cmd_ready  in  1  controller accepts
ctl_cmd_wr  out  1  direction
ctl_addr  out  APP_AD_WIDTH  address
ctl_wdata  out  APP_DW  write data
ctl_rd_valid  in  1  controller read data valid
ctl_rd_data  in  APP_DW  controller read data
rd_outstanding  out  log2(RD_TAG_DEPTH)+1  reads issued, not yet returned
err_unexp_rd  out  1  sticky: ctl_rd_valid with no outstanding read

Behaviour:
- Reset: all outputs 0; rr pointer = 0; hold counter = 0; tag FIFO empty; arbiter in ARB.
- Output stage: one register slot. It is free when ctl_cmd_valid = 0 or (ctl_cmd_valid and ctl_cmd_ready). A grant occurs only when the slot is free. Granted command appears on ctl_* on the next cycle. ctl_* stay stable while ctl_cmd_valid and !ctl_cmd_ready.
- port_cmd_ready[i] is combinational. It is high only for the granted port in a cycle where the slot is free. Transfer happens when port_cmd_valid[i] and port_cmd_ready[i] are both high.
- Eligibility: port i is eligible when valid[i] = 1. A read is additionally ineligible when the tag FIFO is full (rd_outstanding == RD_TAG_DEPTH). A pop in the same cycle does not free a slot for that cycle.
- FSM ARB: grant the first eligible port scanning from rr pointer upward, wrapping mod NUM_PORTS. Set owner = that port, dir = its wr bit, hold counter = 1. Go to HOLD if HOLD_MAX > 1, else stay in ARB with rr = owner+1.
- FSM HOLD: if owner is eligible with the same direction and hold counter < HOLD_MAX, grant owner again and increment the counter. Otherwise set rr = owner+1 (wrapped), return to ARB, and arbitrate in the same cycle, with no bubble.
- Read issue: on a read handshake, push the port index into the tag FIFO in the same cycle.
- Read return: on ctl_rd_valid with the FIFO non-empty, pop the head. Drive port_rd_valid = onehot(head) and port_rd_data = ctl_rd_data registered, giving 1-cycle latency. A simultaneous push and pop leaves rd_outstanding unchanged.
- ctl_rd_valid with FIFO empty: no strobe, no pop, err_unexp_rd <= 1 until reset.
- Writes generate no return.
- Reset asserted mid-operation discards in-flight commands and tags and clears the error.

Test Plan:
- Port 2 only, reads to addr 0x10, 0x11, 0x12 with ctl_cmd_ready = 1 -> ctl_cmd_valid one cycle after each handshake. Controller returns D0..D2 -> port_rd_valid = 4'b0100 three times, data D0..D2 in order.
- All 4 ports continuously valid writes, HOLD_MAX = 4 -> grant sequence 0,0,0,0,1,1,1,1,2,… and no idle cycle on ctl_cmd_valid.
- Port 0 alternates read/write, port 1 writes, HOLD_MAX = 4 -> port 0 gets a single grant before a direction change releases to port 1.
- 16 reads issued with no returns -> rd_outstanding = 16, further reads stalled, writes still granted. One return -> reads re-enabled the cycle after.
- ctl_cmd_ready held 0 for 5 cycles with a pending command -> ctl_* stable, all port_cmd_ready = 0.
- ctl_rd_valid with rd_outstanding = 0 -> err_unexp_rd = 1 sticky, no port_rd_valid. Then sysReset -> cleared.
